// File: rtl/switch_debounce_conditioner_pkg.sv
// Shared types and sizing helpers for the switch debounce conditioner.
package switch_debounce_conditioner_pkg;

  // Per-channel decision for the current clock edge.
  typedef enum logic [1:0] {
    CH_STABLE   = 2'd0,
    CH_COUNTING = 2'd1,
    CH_ACCEPT   = 2'd2
  } ch_phase_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned width_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debounce_channel.sv
// One switch channel: 2-FF synchroniser, tick-gated stability counter and edge pulses.
module switch_debounce_channel
  import switch_debounce_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic debounced,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = width_min1(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             level_next;
  ch_phase_e        phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A synchronised level matching the output always clears the count, tick or not.
  always_comb begin
    phase = CH_COUNTING;
    if (s2 == debounced) begin
      phase = CH_STABLE;
    end else if (tick && (count == CNT_LAST)) begin
      phase = CH_ACCEPT;
    end
  end

  always_comb begin
    count_next = count;
    level_next = debounced;
    case (phase)
      CH_STABLE: begin
        count_next = '0;
      end
      CH_COUNTING: begin
        if (tick) begin
          count_next = count + CNT_W'(1);
        end
      end
      CH_ACCEPT: begin
        count_next = '0;
        level_next = s2;
      end
      default: begin
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      debounced <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      count     <= count_next;
      debounced <= level_next;
      rise      <= (phase == CH_ACCEPT) && s2;
      fall      <= (phase == CH_ACCEPT) && !s2;
    end
  end

endmodule

// File: rtl/switch_debounce_conditioner.sv
// Debounces WIDTH raw switch inputs for the PIO port; holds the shared tick prescaler.
module switch_debounce_conditioner
  import switch_debounce_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned PRESCALE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] debounced,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned PRE_W = width_min1(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_count;
  logic             tick;

  // With PRESCALE=1 the counter sits at zero and every cycle is a tick.
  assign tick = (pre_count == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_count <= '0;
    end else if (tick) begin
      pre_count <= '0;
    end else begin
      pre_count <= pre_count + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_channel
    switch_debounce_channel #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_in[i]),
      .tick     (tick),
      .debounced(debounced[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
  end

  assign changed = |(rise | fall);

endmodule

// File: tb/tb_switch_debounce_conditioner.sv
// Self-checking bench: a 4-channel unit (TICKS=4, PRESCALE=1) and a prescaled 1-channel unit.
module tb_switch_debounce_conditioner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_m = 1'b1;
  logic [3:0] raw_m   = 4'b0000;
  logic [3:0] deb_m, rise_m, fall_m;
  logic       chg_m;

  logic reset_p = 1'b1;
  logic raw_p   = 1'b0;
  logic deb_p, rise_p, fall_p, chg_p;

  switch_debounce_conditioner #(
    .WIDTH(4), .DEBOUNCE_TICKS(4), .PRESCALE(1)
  ) dut_m (
    .clk      (clk),
    .reset    (reset_m),
    .raw_in   (raw_m),
    .debounced(deb_m),
    .rise     (rise_m),
    .fall     (fall_m),
    .changed  (chg_m)
  );

  switch_debounce_conditioner #(
    .WIDTH(1), .DEBOUNCE_TICKS(3), .PRESCALE(5)
  ) dut_p (
    .clk      (clk),
    .reset    (reset_p),
    .raw_in   (raw_p),
    .debounced(deb_p),
    .rise     (rise_p),
    .fall     (fall_p),
    .changed  (chg_p)
  );

  typedef struct {
    string       label;
    logic [16:0] expect_bits;
  } sb_entry_t;

  typedef struct {
    string      label;
    int         count;
    logic       rst;
    logic [3:0] raw;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  sb_entry_t sb[$];
  vec_t      tbl[$];
  int        tests_run    = 0;
  int        tests_failed = 0;

  logic [3:0] e_deb_m  = '0;
  logic [3:0] e_rise_m = '0;
  logic [3:0] e_fall_m = '0;
  logic       e_deb_p  = 1'b0;
  logic       e_rise_p = 1'b0;
  logic       e_fall_p = 1'b0;

  function automatic logic [16:0] pack_expect();
    return {e_deb_m, e_rise_m, e_fall_m, |(e_rise_m | e_fall_m),
            e_deb_p, e_rise_p, e_fall_p, (e_rise_p | e_fall_p)};
  endfunction

  task automatic add_vec(input string label, input int count, input logic rst,
                         input logic [3:0] raw, input logic [3:0] deb,
                         input logic [3:0] rise, input logic [3:0] fall);
    vec_t v;
    v.label = label;
    v.count = count;
    v.rst   = rst;
    v.raw   = raw;
    v.deb   = deb;
    v.rise  = rise;
    v.fall  = fall;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; the expectation describes outputs after the next rising edge.
  task automatic apply_stimulus(input string label, input logic rm, input logic [3:0] wm,
                                input logic rp, input logic wp);
    sb_entry_t e;
    @(negedge clk);
    reset_m = rm;
    raw_m   = wm;
    reset_p = rp;
    raw_p   = wp;
    e.label       = label;
    e.expect_bits = pack_expect();
    sb.push_back(e);
  endtask

  task automatic check_output(input sb_entry_t e);
    logic [16:0] got;
    got = {deb_m, rise_m, fall_m, chg_m, deb_p, rise_p, fall_p, chg_p};
    tests_run++;
    if (got !== e.expect_bits) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", e.label, got, e.expect_bits);
    end
  endtask

  always @(posedge clk) begin
    sb_entry_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_output(e);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    string lbl;
    logic  wp;

    add_vec("reset held",        3, 1'b1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_vec("post-reset count",  5, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_vec("post-reset rise",   1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add_vec("high stable",       4, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_vec("fall count",        5, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    add_vec("fall pulse",        1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add_vec("low stable",        3, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("clean rise count",  5, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add_vec("clean rise pulse",  1, 1'b0, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
    add_vec("clean rise hold",   2, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_vec("bounce burst",      3, 1'b0, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    add_vec("bounce gap",        1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    add_vec("bounce recount",    5, 1'b0, 4'b0101, 4'b0001, 4'b0000, 4'b0000);
    add_vec("bounce rise",       1, 1'b0, 4'b0101, 4'b0101, 4'b0100, 4'b0000);
    add_vec("bounce hold",       3, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
    add_vec("dual fall count",   5, 1'b0, 4'b0000, 4'b0101, 4'b0000, 4'b0000);
    add_vec("dual fall pulse",   1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0101);
    add_vec("dual low hold",     2, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("dual rise count",   5, 1'b0, 4'b0101, 4'b0000, 4'b0000, 4'b0000);
    add_vec("dual rise pulse",   1, 1'b0, 4'b0101, 4'b0101, 4'b0101, 4'b0000);
    add_vec("dual high hold",    2, 1'b0, 4'b0101, 4'b0101, 4'b0000, 4'b0000);
    add_vec("swap count",        5, 1'b0, 4'b0110, 4'b0101, 4'b0000, 4'b0000);
    add_vec("swap pulse",        1, 1'b0, 4'b0110, 4'b0110, 4'b0010, 4'b0001);
    add_vec("swap hold",         2, 1'b0, 4'b0110, 4'b0110, 4'b0000, 4'b0000);
    add_vec("pre-reset count",   4, 1'b0, 4'b0111, 4'b0110, 4'b0000, 4'b0000);
    add_vec("mid-count reset",   2, 1'b1, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    add_vec("restart count",     5, 1'b0, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
    add_vec("restart rise",      1, 1'b0, 4'b0111, 4'b0111, 4'b0111, 4'b0000);
    add_vec("restart hold",      2, 1'b0, 4'b0111, 4'b0111, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].count; c++) begin
        e_deb_m  = tbl[i].deb;
        e_rise_m = tbl[i].rise;
        e_fall_m = tbl[i].fall;
        e_deb_p  = 1'b0;
        e_rise_p = 1'b0;
        e_fall_p = 1'b0;
        apply_stimulus(tbl[i].label, tbl[i].rst, tbl[i].raw, 1'b1, 1'b0);
      end
    end

    // Prescaled unit: ticks land on edges 4, 9, 14, ... after release; two glitches, then a fall.
    e_deb_m  = 4'b0111;
    e_rise_m = 4'b0000;
    e_fall_m = 4'b0000;
    for (int k = 0; k < 53; k++) begin
      wp = !((k == 18) || (k == 19) || (k == 22) || (k == 23) || (k >= 35));
      e_deb_p  = (k >= 14) && (k <= 48);
      e_rise_p = (k == 14);
      e_fall_p = (k == 49);
      if (k < 14)       lbl = "prescale count";
      else if (k == 14) lbl = "prescale rise";
      else if (k < 24)  lbl = "glitch between ticks";
      else if (k < 35)  lbl = "glitch across tick";
      else if (k < 49)  lbl = "prescale fall count";
      else if (k == 49) lbl = "prescale fall";
      else              lbl = "prescale low hold";
      apply_stimulus(lbl, 1'b0, 4'b0111, 1'b0, wp);
    end

    @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
